orb_fill_arb: RTL and testbench
===============================

Name: orb_fill_arb

Overview:
Write-side scheduler for the 2x2048-word ping-pong telemetry buffer drained by the orbit serializer.
- Arbitrates two word sources (LCB channel 1 and 2) into the half not being read.
- Tracks the fill pointer, and swaps halves on every toggle of the serializer's switch flag.
- Flags underrun when a half is released to the reader before it is completely filled.

Parameters:
ADDR_W, 11, word-address width within one half (half depth = 2**ADDR_W = 2048)
DATA_W, 12, word width
BURST_LEN, 16, maximum words written per grant
TIMEOUT, 255, idle cycles (no valid) inside a grant before the grant is revoked

Ports:
iClkOrb  in  1  clock
reset  in  1  asynchronous, active-low reset
iSwitch  in  1  ping-pong select from serializer; reader owns half iSwitch, writer owns half ~iSwitch
iReq1  in  1  channel 1 request, level
iReq2  in  1  channel 2 request, level
iVal1  in  1  channel 1 word valid, honoured only while oGnt1=1
iVal2  in  1  channel 2 word valid, honoured only while oGnt2=1
iData1  in  DATA_W  channel 1 word
iData2  in  DATA_W  channel 2 word
oGnt1  out  1  channel 1 grant
oGnt2  out  1  channel 2 grant
oWrEn  out  1  RAM write strobe
oWrAddr  out  ADDR_W+1  {half, pointer}
oWrData  out  DATA_W  RAM write data
oFillCnt  out  ADDR_W+1  words written into the current write half, 0..2048
oFull  out  1  write half complete
oUnderrun  out  1  one-cycle pulse on a swap with oFillCnt<2048

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0.
- State IDLE, pointer 0, last-served = channel 2, so channel 1 wins the first tie.
- sw_q (registered copy of iSwitch) is loaded from iSwitch on the first clock after reset release.
- No edge is reported on that first clock.

Swap detection:
- edge = (iSwitch != sw_q) on a clock.
- The edge has priority over every other action in that cycle.
- On the edge:
  - pointer <= 0 and oFillCnt <= 0; write half becomes ~iSwitch.
  - oGnt1/oGnt2 <= 0 and state <= IDLE.
  - Any valid word sampled in the edge cycle is discarded (no oWrEn).
  - oUnderrun=1 for one cycle if oFillCnt was below 2048 before the swap. It does not fire on a full half.

State machine:
- IDLE:
  - If only one request is active, grant that channel.
  - If both are active, grant the channel opposite last-served (round-robin).
  - The grant asserts on the clock after the request is sampled.
  - State moves to GRANT and the burst counter and timeout counter are cleared.
- GRANT:
  - Each cycle with oGntN=1 and iValN=1 registers one write.
  - The write appears next cycle: oWrEn=1, oWrAddr={~sw, pointer}, oWrData=iDataN. Write latency is 1 clock.
  - pointer, oFillCnt and the burst counter each increment by 1 per accepted word.
  - A cycle without valid increments the timeout counter; an accepted word clears it.
- Grant end: the grant drops on the clock following the first of these conditions:
  - the burst counter reaches BURST_LEN;
  - iReqN is deasserted;
  - the timeout counter reaches TIMEOUT;
  - oFillCnt reaches 2048.
- After a grant ends:
  - last-served <= N.
  - Next state is GAP (one cycle with no grant), then IDLE.
  - If oFillCnt=2048, next state is FULL instead.
- FULL: oFull=1, no grants, valids ignored; only a swap edge leaves FULL.
- oFull is cleared on the swap edge.

Boundary rules:
- The pointer never wraps within a half. The 2048th word sets oFull, and further valid words in that cycle are ignored.
- A valid on the non-granted channel is always ignored.
- When reset is asserted mid-burst, outputs clear immediately. Partial half contents are not reported as underrun.

Optional Feature:
ORB_FILL_FIXPRIO_EN
- Defined: fixed priority; channel 1 always wins a simultaneous request in IDLE. last-served is not used for arbitration.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset release, iSwitch=0, iReq1=1, iVal1 held high → oGnt1 rises 1 clock later. 16 writes at oWrAddr 0x800..0x80F with data matching iData1. Grant drops after the 16th word, followed by one GAP cycle.
- iReq1 and iReq2 held high continuously, both valids high → grants alternate 1,2,1,2 (fixed 1,1,1 with ORB_FILL_FIXPRIO_EN). oWrAddr is contiguous across grants.
- Continuous fill of 2048 words → oFillCnt=2048, oFull=1, grants stop. The next iSwitch toggle gives oUnderrun=0, oFillCnt=0, and new writes at 0x000.
- Toggle iSwitch after 100 words → oUnderrun pulses for exactly 1 cycle. oFillCnt becomes 0 and the active grant drops in the edge cycle.
- Grant channel 2, iVal2 held low for 255 cycles → grant revoked, no write, and channel 1 is granted next if it is requesting.
- Assert reset mid-burst at word 7 → all outputs read 0 asynchronously. After release, writing restarts at pointer 0.

Source files
------------

// File: rtl/orb_fill_arb.sv
// orb_fill_arb -- write-side scheduler for the 2 x 2**ADDR_W word ping-pong
// telemetry buffer drained by the orbit serializer.
//
// Two level-request word sources (LCB channel 1 and 2) are arbitrated into
// the half the serializer is not reading. The fill pointer is tracked per
// half. Each toggle of iSwitch swaps halves. A swap that releases a half
// before it is completely filled raises a one-cycle underrun pulse.
//
// Ports:
//   iClkOrb      clock
//   reset        asynchronous, active-low reset
//   iSwitch      reader owns half iSwitch, writer owns half ~iSwitch
//   iReq1/2      channel requests (level)
//   iVal1/2      word valid, honoured only while the matching grant is high
//   iData1/2     channel words
//   oGnt1/2      channel grants
//   oWrEn        RAM write strobe (one clock after the accepted word)
//   oWrAddr      {half, pointer}
//   oWrData      RAM write data
//   oFillCnt     words written into the current write half (0..2**ADDR_W)
//   oFull        write half complete
//   oUnderrun    one-cycle pulse on a swap of a partially filled half
//
// Handshake: a word transfers on every rising clock where oGntN=1 and
// iValN=1. There is no backpressure inside a grant; the grant itself is the
// ready signal, and it is only ever removed on a clock edge.
//
// Build option: define ORB_FILL_FIXPRIO_EN for fixed priority (channel 1
// always wins a simultaneous request). Default is round-robin.

module orb_fill_arb #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 12,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              iClkOrb,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic              iReq1,
  input  logic              iReq2,
  input  logic              iVal1,
  input  logic              iVal2,
  input  logic [DATA_W-1:0] iData1,
  input  logic [DATA_W-1:0] iData2,
  output logic              oGnt1,
  output logic              oGnt2,
  output logic              oWrEn,
  output logic [ADDR_W:0]   oWrAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic [ADDR_W:0]   oFillCnt,
  output logic              oFull,
  output logic              oUnderrun
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP, S_FULL} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sw_q;
  logic                r_sw_vld;   // sw_q holds a real sample (not on first clock after reset)
  logic                r_gnt1, w_gnt1_nxt;
  logic                r_gnt2, w_gnt2_nxt;
  logic                r_last, w_last_nxt;   // 1 = channel 2 served last
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [ADDR_W:0]     r_fill, w_fill_nxt;
  logic [BW-1:0]       r_burst, w_burst_nxt;
  logic [TW-1:0]       r_tmo, w_tmo_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [ADDR_W:0]     r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic                r_full, w_full_nxt;
  logic                r_underrun, w_underrun_nxt;

  logic w_edge;
  logic w_acc1;
  logic w_acc2;
  logic w_pick2;
  logic w_req_g;

  assign w_edge  = r_sw_vld && (iSwitch != r_sw_q);
  assign w_acc1  = r_gnt1 && iVal1;
  assign w_acc2  = r_gnt2 && iVal2;
  assign w_req_g = r_gnt1 ? iReq1 : iReq2;

`ifdef ORB_FILL_FIXPRIO_EN
  assign w_pick2 = iReq2 && !iReq1;
`else
  // On a tie, serve the channel that was not served last.
  assign w_pick2 = iReq2 && (!iReq1 || !r_last);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt1_nxt     = r_gnt1;
    w_gnt2_nxt     = r_gnt2;
    w_last_nxt     = r_last;
    w_ptr_nxt      = r_ptr;
    w_fill_nxt     = r_fill;
    w_burst_nxt    = r_burst;
    w_tmo_nxt      = r_tmo;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_full_nxt     = r_full;
    w_underrun_nxt = 1'b0;

    if (w_edge) begin
      // Swap wins over everything: any word sampled this cycle is dropped.
      w_state_nxt    = S_IDLE;
      w_gnt1_nxt     = 1'b0;
      w_gnt2_nxt     = 1'b0;
      w_ptr_nxt      = '0;
      w_fill_nxt     = '0;
      w_full_nxt     = 1'b0;
      w_underrun_nxt = (r_fill != FULL_CNT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iReq1 || iReq2) begin
            w_gnt1_nxt  = !w_pick2;
            w_gnt2_nxt  = w_pick2;
            w_burst_nxt = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_acc1 || w_acc2) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = {~r_sw_q, r_ptr};
            w_wr_data_nxt = w_acc1 ? iData1 : iData2;
            w_fill_nxt    = r_fill + 1'b1;
            w_burst_nxt   = r_burst + 1'b1;
            w_tmo_nxt     = '0;
            // Pointer holds at the last word of the half rather than wrapping.
            if (w_fill_nxt != FULL_CNT) w_ptr_nxt = r_ptr + 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
          // Limits are tested on the post-update counts so no extra word
          // slips in after the limit is reached.
          if ((w_burst_nxt == BW'(BURST_LEN)) || (w_fill_nxt == FULL_CNT) ||
              (w_tmo_nxt == TW'(TIMEOUT)) || !w_req_g) begin
            w_gnt1_nxt = 1'b0;
            w_gnt2_nxt = 1'b0;
            w_last_nxt = r_gnt2;
            if (w_fill_nxt == FULL_CNT) begin
              w_state_nxt = S_FULL;
              w_full_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
            end
          end
        end
        S_GAP:   w_state_nxt = S_IDLE;
        S_FULL:  w_state_nxt = S_FULL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClkOrb or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sw_q     <= 1'b0;
      r_sw_vld   <= 1'b0;
      r_gnt1     <= 1'b0;
      r_gnt2     <= 1'b0;
      r_last     <= 1'b1;
      r_ptr      <= '0;
      r_fill     <= '0;
      r_burst    <= '0;
      r_tmo      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sw_q     <= iSwitch;
      r_sw_vld   <= 1'b1;
      r_gnt1     <= w_gnt1_nxt;
      r_gnt2     <= w_gnt2_nxt;
      r_last     <= w_last_nxt;
      r_ptr      <= w_ptr_nxt;
      r_fill     <= w_fill_nxt;
      r_burst    <= w_burst_nxt;
      r_tmo      <= w_tmo_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_full     <= w_full_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign oGnt1     = r_gnt1;
  assign oGnt2     = r_gnt2;
  assign oWrEn     = r_wr_en;
  assign oWrAddr   = r_wr_addr;
  assign oWrData   = r_wr_data;
  assign oFillCnt  = r_fill;
  assign oFull     = r_full;
  assign oUnderrun = r_underrun;

endmodule

// File: tb/tb_orb_fill_arb.sv
// Bench for orb_fill_arb. Stimulus runs on falling edges; every word handed
// over (grant and valid high before a rising edge) is pushed into exp_q with
// its expected {half, pointer, data}, and a monitor pops and compares each
// RAM write one time unit after the rising edge.

module tb_orb_fill_arb;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 12;
  localparam int W      = ADDR_W + 1 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sw = 1'b0;
  logic              req1 = 1'b0, req2 = 1'b0;
  logic              val1 = 1'b0, val2 = 1'b0;
  logic [DATA_W-1:0] data1 = '0, data2 = '0;
  logic              gnt1, gnt2, wr_en, full, underrun;
  logic [ADDR_W:0]   wr_addr, fill;
  logic [DATA_W-1:0] wr_data;

  orb_fill_arb dut (
    .iClkOrb(clk), .reset(rst_n), .iSwitch(sw),
    .iReq1(req1), .iReq2(req2), .iVal1(val1), .iVal2(val2),
    .iData1(data1), .iData2(data2),
    .oGnt1(gnt1), .oGnt2(gnt2), .oWrEn(wr_en), .oWrAddr(wr_addr),
    .oWrData(wr_data), .oFillCnt(fill), .oFull(full), .oUnderrun(underrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // bench-side model of the write pointer
  logic [ADDR_W-1:0] ptr_m = '0;
  logic              sw_prev = 1'b0;
  logic              armed = 1'b0;
  int                pushed = 0;
  logic [11:0]       cyc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   wr_addr, wr_data, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // Called at a falling edge with inputs set for the coming rising edge.
  task automatic tick();
    if (rst_n) begin
      if (armed && (sw != sw_prev)) begin
        ptr_m = '0;   // swap cycle: word dropped, new half starts at 0
      end else begin
        if (gnt1 && val1) begin
          exp_q.push_back({~sw, ptr_m, data1});
          ptr_m++;
          pushed++;
        end
        if (gnt2 && val2) begin
          exp_q.push_back({~sw, ptr_m, data2});
          ptr_m++;
          pushed++;
        end
      end
      sw_prev = sw;
      armed   = 1'b1;
    end
    @(negedge clk);
    cyc++;
    data1 = cyc ^ 12'h5A5;
    data2 = ~cyc;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_gnt2"}, gnt2, 0);
    chk({tag, "_wren"}, wr_en, 0);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_fill"}, fill, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic do_reset();
    chk("drain_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    req1 = 0; req2 = 0; val1 = 0; val2 = 0; sw = 0;
    exp_q.delete();
    ptr_m = '0; armed = 1'b0; pushed = 0;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int owners[4];
    int n_own;
    int cnt;
    logic prev_any;

    repeat (2) @(negedge clk);
    do_reset();

    // ---- single channel burst: 16 words at 0x800.. then grant low 2 cycles
    req1 = 1; val1 = 1; rst_n = 1;
    chk("gnt1_before_first_clk", gnt1, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("burst_gnt1_high", gnt1, 1);
      tick();
    end
    chk("burst_fill16", fill, 16);
    chk("burst_gap_gnt1_a", gnt1, 0);
    tick();
    chk("burst_gap_gnt1_b", gnt1, 0);
    tick();
    chk("burst_regrant", gnt1, 1);
    do_reset();

    // ---- both channels: arbitration order, then fill the whole half
    req1 = 1; req2 = 1; val1 = 1; val2 = 1; rst_n = 1;
    n_own = 0; prev_any = 0; cnt = 0;
    while (!full && cnt < 5000) begin
      if ((gnt1 || gnt2) && !prev_any && n_own < 4) begin
        owners[n_own] = gnt1 ? 1 : 2;
        n_own++;
      end
      prev_any = gnt1 || gnt2;
      tick();
      cnt++;
    end
    chk("owners_seen", n_own, 4);
`ifdef ORB_FILL_FIXPRIO_EN
    chk("owner0", owners[0], 1); chk("owner1", owners[1], 1);
    chk("owner2", owners[2], 1); chk("owner3", owners[3], 1);
`else
    chk("owner0", owners[0], 1); chk("owner1", owners[1], 2);
    chk("owner2", owners[2], 1); chk("owner3", owners[3], 2);
`endif
    chk("full_flag", full, 1);
    chk("full_fillcnt", fill, 2048);
    chk("full_words", pushed, 2048);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_grant", gnt1 | gnt2, 0);
    end
    chk("full_held", full, 1);

    // ---- swap of a full half: no underrun, writes restart at 0x000
    sw = 1;
    tick();
    chk("swap_full_underrun", underrun, 0);
    chk("swap_full_fill", fill, 0);
    chk("swap_full_cleared", full, 0);
    pushed = 0;
    cnt = 0;
    while (pushed < 100 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("partial_words", pushed, 100);

    // ---- swap after 100 words: underrun pulse, grant dropped
    sw = 0;
    tick();
    chk("underrun_pulse", underrun, 1);
    chk("underrun_fill", fill, 0);
    chk("underrun_gnt_drop", gnt1 | gnt2, 0);
    tick();
    chk("underrun_one_cycle", underrun, 0);
    req1 = 0; req2 = 0;
    repeat (4) tick();
    do_reset();

    // ---- timeout on channel 2, channel 1 waiting
    req2 = 1; rst_n = 1;
    tick();
    chk("tmo_gnt2", gnt2, 1);
    req1 = 1;
    cnt = 0;
    while (gnt2 && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("tmo_cycles", cnt, 255);
    chk("tmo_gnt1_gap", gnt1, 0);
    tick();
    tick();
    chk("tmo_then_gnt1", gnt1, 1);
    chk("tmo_no_writes", fill, 0);
    req1 = 0; req2 = 0;
    tick();
    do_reset();

    // ---- reset mid-burst at word 7, then restart at pointer 0
    req1 = 1; val1 = 1; rst_n = 1;
    cnt = 0;
    while (pushed < 7 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("midreset_fill7", fill, 7);
    #2;
    do_reset();
    req1 = 1; val1 = 1; rst_n = 1;
    cnt = 0;
    while (pushed < 5 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("restart_words", pushed, 5);
    req1 = 0; val1 = 0;
    repeat (4) tick();
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
